// File: rtl/psram_pkg.sv
// Shared encodings for the PSRAM request sequencer: bus width codes, command
// opcodes and the sequencer state enumeration.
package psram_pkg;

    // Lane width codes understood by psram_ctrl for cmd/addr/data phases
    localparam logic [1:0] W_SINGLE = 2'b00;
    localparam logic [1:0] W_DUAL   = 2'b01;
    localparam logic [1:0] W_QUAD   = 2'b10;

    // Power-up sequence opcodes
    localparam logic [7:0] CMD_RSTEN = 8'h66;
    localparam logic [7:0] CMD_RST   = 8'h99;
    localparam logic [7:0] CMD_QE    = 8'h35;

    // Data transfer opcodes: quad variants and plain SPI variants
    localparam logic [7:0] CMD_QWR   = 8'h38;
    localparam logic [7:0] CMD_QRD   = 8'hEB;
    localparam logic [7:0] CMD_WR    = 8'h02;
    localparam logic [7:0] CMD_RD    = 8'h03;

    typedef enum logic [2:0] {
        ST_INIT_RSTEN = 3'd0,
        ST_INIT_RST   = 3'd1,
        ST_INIT_QE    = 3'd2,
        ST_IDLE       = 3'd3,
        ST_ISSUE      = 3'd4,
        ST_WAIT_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/psram_chunk_calc.sv
// Sizes the next psram_ctrl transaction of a request: the largest word count
// that neither exceeds the words left, crosses a PSRAM page, nor exceeds the
// per-transaction burst limit. Also yields the ctrl byte length and the
// address/remaining count once that chunk has completed.
module psram_chunk_calc #(
    parameter int PAGE_BYTES      = 1024,
    parameter int MAX_BURST_WORDS = 32
) (
    input  logic [23:0] cur_addr,
    input  logic [8:0]  rem,
    output logic [8:0]  chunk,
    output logic [14:0] data_len,
    output logic [23:0] next_addr,
    output logic [8:0]  rem_next
);

    localparam logic [24:0] PAGE_SIZE = 25'(PAGE_BYTES);
    localparam logic [23:0] PAGE_MASK = 24'(PAGE_BYTES - 1);
    localparam logic [8:0]  MAX_WORDS = 9'(MAX_BURST_WORDS);

    logic [24:0] page_left;
    logic [24:0] page_words;
    logic [8:0]  room;

    // Bytes to the end of the current page, then words; a request never asks
    // for more than 256 words so the page room is clamped to that range.
    assign page_left  = PAGE_SIZE - {1'b0, cur_addr & PAGE_MASK};
    assign page_words = page_left >> 2;
    assign room       = (page_words > 25'd256) ? 9'd256 : page_words[8:0];

    // Minimum of words remaining, page room and burst limit
    always_comb begin
        chunk = rem;
        if (room < chunk) chunk = room;
        if (MAX_WORDS < chunk) chunk = MAX_WORDS;
    end

    assign data_len  = {4'b0000, chunk, 2'b00} - 15'd1;
    assign next_addr = cur_addr + {13'd0, chunk, 2'b00};
    assign rem_next  = rem - chunk;

endmodule

// File: rtl/psram_req_seq.sv
// Request sequencer in front of psram_ctrl. After reset it issues the PSRAM
// power-up commands, then splits word-granular system read/write requests
// into page-safe, burst-limited ctrl transactions and steers the word streams
// between the system side and the ctrl DMA port.
module psram_req_seq
    import psram_pkg::*;
#(
    parameter int QUAD_EN         = 1,
    parameter int PAGE_BYTES      = 1024,
    parameter int MAX_BURST_WORDS = 32,
    parameter int RD_WAIT         = 6,
    parameter int SCK_DIV         = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        init_done,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_wr,
    input  logic [23:0] req_addr,
    input  logic [8:0]  req_len,
    output logic        req_done,
    input  logic        wdata_vld,
    input  logic [31:0] wdata,
    output logic        wdata_rdy,
    output logic        rdata_vld,
    output logic [31:0] rdata,
    input  logic        rdata_rdy,
    output logic        start,
    output logic [7:0]  cmd,
    output logic        cmd_only,
    output logic [1:0]  cmd_width,
    output logic [23:0] addr,
    output logic [1:0]  addr_width,
    output logic [3:0]  wait_cyc,
    output logic        data_dir,
    output logic [14:0] data_len,
    output logic [1:0]  data_width,
    output logic        single_line_io_mode,
    output logic [3:0]  sck_div,
    output logic        tx_vld,
    output logic [31:0] tx_data,
    input  logic        tx_free,
    output logic        rx_rdy,
    input  logic        rx_vld,
    input  logic [31:0] rx_data,
    input  logic        done
);

    localparam logic [1:0]  XFER_W   = (QUAD_EN != 0) ? W_QUAD  : W_SINGLE;
    localparam logic [7:0]  WR_OP    = (QUAD_EN != 0) ? CMD_QWR : CMD_WR;
    localparam logic [7:0]  RD_OP    = (QUAD_EN != 0) ? CMD_QRD : CMD_RD;
    localparam logic [3:0]  RD_WC    = (QUAD_EN != 0) ? 4'(RD_WAIT) : 4'd0;
    localparam logic [23:0] ADDR_ALN = 24'hFF_FFFC;

    state_t      state;
    state_t      ret_st;
    state_t      init_ret;
    logic [7:0]  init_cmd;
    logic        data_xfer;
    logic        dir;
    logic [23:0] cur_addr;
    logic [8:0]  rem;
    logic [8:0]  chunk;
    logic [8:0]  rem_next;
    logic [14:0] chunk_len;
    logic [23:0] next_addr;
    logic [8:0]  wcnt;
    logic [8:0]  wcnt_nxt;
    logic        win;
    logic        win_hs;
    logic        req_hs;
    logic        chunk_done;
    logic        cnt_err;

    psram_chunk_calc #(
        .PAGE_BYTES      (PAGE_BYTES),
        .MAX_BURST_WORDS (MAX_BURST_WORDS)
    ) u_chunk (
        .cur_addr  (cur_addr),
        .rem       (rem),
        .chunk     (chunk),
        .data_len  (chunk_len),
        .next_addr (next_addr),
        .rem_next  (rem_next)
    );

    assign sck_div             = 4'(SCK_DIV);
    assign single_line_io_mode = 1'b0;

    // The word streams are only connected while a data transaction is in flight
    assign win        = (state == ST_WAIT_DONE) && data_xfer;
    assign tx_vld     = win & dir & wdata_vld;
    assign tx_data    = wdata;
    assign wdata_rdy  = win & dir & tx_free;
    assign rx_rdy     = win & ~dir & rdata_rdy;
    assign rdata_vld  = win & ~dir & rx_vld;
    assign rdata      = rx_data;
    assign win_hs     = win & (dir ? (wdata_vld & tx_free) : (rx_vld & rdata_rdy));
    assign wcnt_nxt   = wcnt + 9'(win_hs);
    assign req_hs     = (state == ST_IDLE) && req_rdy && req_vld;
    assign chunk_done = win && done;

    // Opcode for the current init step and where the sequence goes after it
    always_comb begin
        init_cmd = CMD_RSTEN;
        init_ret = ST_INIT_RST;
        case (state)
            ST_INIT_RST: begin
                init_cmd = CMD_RST;
                init_ret = (QUAD_EN != 0) ? ST_INIT_QE : ST_IDLE;
            end
            ST_INIT_QE: begin
                init_cmd = CMD_QE;
                init_ret = ST_IDLE;
            end
            default: ;
        endcase
    end

    // Request bookkeeping: latched on acceptance, advanced per completed chunk
    always_ff @(posedge clk) begin
        if (req_hs) begin
            cur_addr <= req_addr & ADDR_ALN;
            rem      <= req_len;
            dir      <= req_wr;
        end else if (chunk_done) begin
            cur_addr <= next_addr;
            rem      <= rem_next;
        end
    end

    // Sequencer FSM driving the registered ctrl fields, start and handshakes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_INIT_RSTEN;
            ret_st     <= ST_INIT_RST;
            data_xfer  <= 1'b0;
            start      <= 1'b0;
            req_rdy    <= 1'b0;
            req_done   <= 1'b0;
            init_done  <= 1'b0;
            cmd        <= 8'h00;
            cmd_only   <= 1'b0;
            cmd_width  <= W_SINGLE;
            addr       <= 24'd0;
            addr_width <= W_SINGLE;
            wait_cyc   <= 4'd0;
            data_dir   <= 1'b0;
            data_len   <= 15'd0;
            data_width <= W_SINGLE;
            wcnt       <= 9'd0;
            cnt_err    <= 1'b0;
        end else begin
            start    <= 1'b0;
            req_done <= 1'b0;
            wcnt     <= wcnt_nxt;
            case (state)
                ST_INIT_RSTEN, ST_INIT_RST, ST_INIT_QE: begin
                    cmd        <= init_cmd;
                    cmd_only   <= 1'b1;
                    cmd_width  <= W_SINGLE;
                    addr       <= 24'd0;
                    addr_width <= W_SINGLE;
                    wait_cyc   <= 4'd0;
                    data_dir   <= 1'b0;
                    data_len   <= 15'd0;
                    data_width <= W_SINGLE;
                    data_xfer  <= 1'b0;
                    ret_st     <= init_ret;
                    start      <= 1'b1;
                    state      <= ST_WAIT_DONE;
                end
                ST_IDLE: begin
                    if (!req_rdy) begin
                        req_rdy <= 1'b1;
                    end else if (req_vld) begin
                        req_rdy <= 1'b0;
                        if (req_len == 9'd0) begin
                            req_done <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cmd        <= dir ? WR_OP : RD_OP;
                    cmd_only   <= 1'b0;
                    cmd_width  <= XFER_W;
                    addr       <= cur_addr;
                    addr_width <= XFER_W;
                    wait_cyc   <= dir ? 4'd0 : RD_WC;
                    data_dir   <= dir;
                    data_len   <= chunk_len;
                    data_width <= XFER_W;
                    data_xfer  <= 1'b1;
                    wcnt       <= 9'd0;
                    start      <= 1'b1;
                    state      <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (done) begin
                        if (data_xfer) begin
                            if (wcnt_nxt != chunk) cnt_err <= 1'b1;
                            if (rem_next == 9'd0) begin
                                req_done <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                state <= ST_ISSUE;
                            end
                        end else begin
                            state <= ret_st;
                            if (ret_st == ST_IDLE) init_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_INIT_RSTEN;
            endcase
        end
    end

    // Every chunk must move exactly the number of words it was sized for
    a_word_count: assert property (@(posedge clk) disable iff (rst) !cnt_err);

endmodule

// File: tb/tb_psram_req_seq.sv
// Bench for psram_req_seq: plays both the system requester and a behavioural
// psram_ctrl, and checks every ctrl transaction and data word against a
// reference list computed from the chunking rules.
module tb_psram_req_seq;

    localparam int PAGE = 1024;
    localparam int MAXB = 32;
    localparam int RDW  = 6;

    logic        clk;
    logic        rst;
    logic        init_done;
    logic        req_vld, req_rdy, req_wr, req_done;
    logic [23:0] req_addr;
    logic [8:0]  req_len;
    logic        wdata_vld, wdata_rdy, rdata_vld, rdata_rdy;
    logic [31:0] wdata, rdata;
    logic        start, cmd_only, data_dir, single_line_io_mode;
    logic [7:0]  cmd;
    logic [1:0]  cmd_width, addr_width, data_width;
    logic [23:0] addr;
    logic [3:0]  wait_cyc, sck_div;
    logic [14:0] data_len;
    logic        tx_vld, tx_free, rx_rdy, rx_vld, done;
    logic [31:0] tx_data, rx_data;

    psram_req_seq #(
        .QUAD_EN(1), .PAGE_BYTES(PAGE), .MAX_BURST_WORDS(MAXB), .RD_WAIT(RDW), .SCK_DIV(1)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
        .req_len(req_len), .req_done(req_done),
        .wdata_vld(wdata_vld), .wdata(wdata), .wdata_rdy(wdata_rdy),
        .rdata_vld(rdata_vld), .rdata(rdata), .rdata_rdy(rdata_rdy),
        .start(start), .cmd(cmd), .cmd_only(cmd_only), .cmd_width(cmd_width),
        .addr(addr), .addr_width(addr_width), .wait_cyc(wait_cyc), .data_dir(data_dir),
        .data_len(data_len), .data_width(data_width),
        .single_line_io_mode(single_line_io_mode), .sck_div(sck_div),
        .tx_vld(tx_vld), .tx_data(tx_data), .tx_free(tx_free),
        .rx_rdy(rx_rdy), .rx_vld(rx_vld), .rx_data(rx_data), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  cmd;
        logic        cmd_only;
        logic [1:0]  wd;
        logic [23:0] addr;
        logic [3:0]  wc;
        logic        dir;
        logic [14:0] len;
    } tr_t;

    tr_t         exp_tr[$];
    logic [31:0] sys_wq[$];
    logic [31:0] exp_rq[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done_cyc = -100;
    int n_start, n_done, n_wr, n_rd, n_reqdone, n_acc, acc_cyc, reqdone_cyc;
    int stall_at = -1;
    int stall_cnt = 0;
    bit stalling;
    bit req_pend = 0;

    bit          ctl_busy = 0;
    bit          ctl_dir;
    int          ctl_left, ctl_lat;
    logic [23:0] ctl_addr;
    logic [58:0] held;
    bit          moved;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        return {a[23:8] ^ 16'hC3A5, a[15:0] + 16'h1234};
    endfunction

    // One clock: drive both sides at the falling edge, then observe what the
    // upcoming rising edge will see.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        done     = 1'b0;
        tx_free  = 1'b0;
        rx_vld   = 1'b0;
        stalling = 1'b0;
        if (ctl_busy) begin
            if (ctl_left == 0) begin
                if (ctl_lat == 0) done = 1'b1;
                else ctl_lat--;
            end else if (ctl_dir) begin
                tx_free = ($urandom_range(0, 3) != 0);
            end else begin
                rx_vld  = ($urandom_range(0, 3) != 0);
                rx_data = mem_word(ctl_addr);
            end
        end
        wdata_vld = (sys_wq.size() > 0) && ($urandom_range(0, 3) != 0);
        if (sys_wq.size() > 0) wdata = sys_wq[0];
        if (stall_cnt > 0) begin
            rdata_rdy = 1'b0;
            stall_cnt--;
            stalling = 1'b1;
        end else begin
            rdata_rdy = ($urandom_range(0, 3) != 0);
        end
        req_vld = req_pend;
        #1;
        if (start) begin
            n_start++;
            check_eq("start_gap", 32'(cyc - last_done_cyc >= 2), 1);
            check_eq("start_while_busy", 32'(ctl_busy), 0);
            if (exp_tr.size() == 0) begin
                check_eq("unexpected_start", 32'(start), 0);
            end else begin
                tr_t e;
                e = exp_tr.pop_front();
                check_eq("cmd", 32'(cmd), 32'(e.cmd));
                check_eq("cmd_only", 32'(cmd_only), 32'(e.cmd_only));
                check_eq("cmd_width", 32'(cmd_width), 32'(e.wd));
                check_eq("addr_width", 32'(addr_width), 32'(e.wd));
                check_eq("data_width", 32'(data_width), 32'(e.wd));
                if (!e.cmd_only) begin
                    check_eq("addr", 32'(addr), 32'(e.addr));
                    check_eq("data_len", 32'(data_len), 32'(e.len));
                    check_eq("wait_cyc", 32'(wait_cyc), 32'(e.wc));
                    check_eq("data_dir", 32'(data_dir), 32'(e.dir));
                end
            end
            ctl_busy = 1'b1;
            ctl_left = cmd_only ? 0 : (int'(data_len) + 1) / 4;
            ctl_dir  = data_dir;
            ctl_addr = addr;
            ctl_lat  = $urandom_range(0, 2);
            held     = {cmd, cmd_only, cmd_width, addr, addr_width, wait_cyc, data_dir, data_len, data_width};
            moved    = 1'b0;
        end else if (ctl_busy) begin
            if ({cmd, cmd_only, cmd_width, addr, addr_width, wait_cyc, data_dir, data_len, data_width} != held)
                moved = 1'b1;
        end
        if (!ctl_busy)
            check_eq("path_closed", {28'd0, tx_vld, wdata_rdy, rx_rdy, rdata_vld}, 0);
        if (stalling)
            check_eq("stall_rx_rdy", 32'(rx_rdy), 0);
        if (wdata_vld && wdata_rdy) begin
            check_eq("wr_in_window", 32'(tx_free && ctl_busy && ctl_left > 0), 1);
            check_eq("tx_vld", 32'(tx_vld), 1);
            check_eq("tx_data", tx_data, sys_wq[0]);
            void'(sys_wq.pop_front());
            ctl_left--;
            n_wr++;
        end
        if (rx_vld && rx_rdy) begin
            check_eq("rdata_vld", 32'(rdata_vld), 1);
            if (exp_rq.size() == 0) begin
                check_eq("extra_rd_word", rdata, 32'hDEAD_BEEF ^ rdata ^ 32'h1);
            end else begin
                check_eq("rdata", rdata, exp_rq.pop_front());
            end
            ctl_addr = ctl_addr + 24'd4;
            ctl_left--;
            n_rd++;
            if (n_rd == stall_at) stall_cnt = 20;
        end
        if (done) begin
            check_eq("fields_held", 32'(moved), 0);
            ctl_busy = 1'b0;
            last_done_cyc = cyc;
            n_done++;
        end
        if (req_vld && req_rdy) begin
            req_pend = 1'b0;
            acc_cyc = cyc;
            n_acc++;
        end
        if (req_done) begin
            n_reqdone++;
            reqdone_cyc = cyc;
        end
    endtask

    task automatic chk_reset_vals();
        check_eq("rst_start", 32'(start), 0);
        check_eq("rst_req_rdy", 32'(req_rdy), 0);
        check_eq("rst_req_done", 32'(req_done), 0);
        check_eq("rst_init_done", 32'(init_done), 0);
        check_eq("rst_cmd", 32'(cmd), 0);
        check_eq("rst_cmd_only", 32'(cmd_only), 0);
        check_eq("rst_widths", {26'd0, cmd_width, addr_width, data_width}, 0);
        check_eq("rst_addr", 32'(addr), 0);
        check_eq("rst_wait_cyc", 32'(wait_cyc), 0);
        check_eq("rst_data_dir", 32'(data_dir), 0);
        check_eq("rst_data_len", 32'(data_len), 0);
        check_eq("rst_single_line", 32'(single_line_io_mode), 0);
        check_eq("rst_streams", {28'd0, tx_vld, rx_rdy, wdata_rdy, rdata_vld}, 0);
    endtask

    task automatic push_init(input logic [7:0] op);
        tr_t t;
        t = '0;
        t.cmd = op;
        t.cmd_only = 1'b1;
        t.wd = 2'b00;
        exp_tr.push_back(t);
    endtask

    task automatic run_init();
        exp_tr.delete();
        push_init(8'h66);
        push_init(8'h99);
        push_init(8'h35);
        n_start = 0;
        n_done = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (init_done) break;
        end
        check_eq("init_done", 32'(init_done), 1);
        check_eq("init_dones_before_flag", 32'(n_done), 3);
        check_eq("init_starts", 32'(n_start), 3);
        check_eq("init_tr_left", 32'(exp_tr.size()), 0);
    endtask

    // Expected transactions and word streams for one request, from the
    // page/burst splitting rule applied with plain integer arithmetic.
    task automatic build_expect(input bit wr, input logic [23:0] a0, input int len);
        logic [23:0] a;
        int r, room, c;
        tr_t t;
        exp_tr.delete();
        sys_wq.delete();
        exp_rq.delete();
        a = a0 & 24'hFF_FFFC;
        for (int i = 0; i < len; i++) begin
            if (wr) sys_wq.push_back($urandom);
            else exp_rq.push_back(mem_word(a + 24'(4 * i)));
        end
        r = len;
        while (r > 0) begin
            room = (PAGE - (int'(a) % PAGE)) / 4;
            c = r;
            if (room < c) c = room;
            if (MAXB < c) c = MAXB;
            t.cmd      = wr ? 8'h38 : 8'hEB;
            t.cmd_only = 1'b0;
            t.wd       = 2'b10;
            t.addr     = a;
            t.wc       = wr ? 4'd0 : 4'(RDW);
            t.dir      = wr;
            t.len      = 15'(c * 4 - 1);
            exp_tr.push_back(t);
            a = a + 24'(c * 4);
            r = r - c;
        end
    endtask

    task automatic launch(input bit wr, input logic [23:0] a0, input int len, input int stall);
        build_expect(wr, a0, len);
        req_wr    = wr;
        req_addr  = a0;
        req_len   = 9'(len);
        req_pend  = 1'b1;
        stall_at  = stall;
        stall_cnt = 0;
        n_start = 0; n_wr = 0; n_rd = 0; n_reqdone = 0; n_acc = 0;
    endtask

    task automatic run_req(input bit wr, input logic [23:0] a0, input int len, input int stall);
        int exp_starts;
        launch(wr, a0, len, stall);
        exp_starts = exp_tr.size();
        for (int i = 0; i < 300 + len * 40 && n_reqdone == 0; i++) cycle();
        repeat (3) cycle();
        check_eq("req_accepted", 32'(n_acc), 1);
        check_eq("req_done_pulses", 32'(n_reqdone), 1);
        check_eq("start_count", 32'(n_start), 32'(exp_starts));
        check_eq("tr_left", 32'(exp_tr.size()), 0);
        check_eq("words_moved", 32'(wr ? n_wr : n_rd), 32'(len));
        check_eq("words_left", 32'(sys_wq.size() + exp_rq.size()), 0);
        if (len == 0) check_eq("len0_done_latency", 32'(reqdone_cyc - acc_cyc), 1);
    endtask

    // Reset in the middle of a read burst, then the init sequence must rerun
    task automatic run_abort();
        launch(1'b0, 24'h002000, 64, -1);
        for (int i = 0; i < 2000 && n_rd < 10; i++) cycle();
        check_eq("abort_reached_burst", 32'(n_rd >= 10), 1);
        #1 rst = 1'b1;
        #1;
        chk_reset_vals();
        exp_tr.delete();
        sys_wq.delete();
        exp_rq.delete();
        ctl_busy = 1'b0;
        req_pend = 1'b0;
        stall_cnt = 0;
        last_done_cyc = -100;
        repeat (3) cycle();
        chk_reset_vals();
        rst = 1'b0;
        run_init();
    endtask

    initial begin
        rst = 1'b1;
        req_vld = 0; req_wr = 0; req_addr = '0; req_len = '0;
        wdata_vld = 0; wdata = '0; rdata_rdy = 0;
        tx_free = 0; rx_vld = 0; rx_data = '0; done = 0;
        repeat (3) cycle();
        chk_reset_vals();
        check_eq("sck_div", 32'(sck_div), 1);
        rst = 1'b0;
        run_init();
        run_req(1'b1, 24'h000100, 4, -1);
        run_req(1'b0, 24'h0003F8, 4, -1);
        run_req(1'b0, 24'h000000, 80, -1);
        run_req(1'b1, 24'h0007FC, 0, -1);
        run_req(1'b0, 24'hFF_FFF8, 4, -1);
        run_req(1'b1, 24'h000203, 5, -1);
        run_req(1'b0, 24'h001000, 40, 10);
        for (int i = 0; i < 12; i++) begin
            logic [23:0] a;
            int len;
            a = 24'($urandom);
            if ($urandom_range(0, 1) != 0) a[9:0] = 10'h3C0 + 10'($urandom_range(0, 63));
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 256);
            run_req(1'($urandom_range(0, 1)), a, len, -1);
        end
        run_abort();
        run_req(1'b0, 24'h000040, 8, -1);
        run_req(1'b1, 24'h0003F0, 12, -1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish got %0d cycles expected fewer", cyc);
        $fatal(1);
    end

endmodule

// File: doc/psram_req_seq.md
Name: psram_req_seq

Overview:
- Request sequencer directly upstream of psram_ctrl.
- Runs the PSRAM power-up command sequence: reset-enable, reset, then optional enter-quad.
- Accepts word-granular read/write requests from the system side and splits each one into page-safe, length-limited psram_ctrl transactions. It drives the ctrl register fields and start, and routes write/read word streams to the ctrl DMA port.

Parameters:
- QUAD_EN, 1: 1 = issue enter-quad at init and use quad cmd/addr/data; 0 = plain SPI.
- PAGE_BYTES, 1024: PSRAM page size. A burst never crosses a page boundary. Power of 2.
- MAX_BURST_WORDS, 32: maximum words per ncs-low transaction (tCEM bound). Range 1..256.
- RD_WAIT, 6: wait cycles for quad read 0xEB. SPI read 0x03 uses 0.
- SCK_DIV, 1: constant driven on sck_div.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- init_done  out  1  high once the init sequence has completed
- req_vld  in  1  request valid
- req_rdy  out  1  request accepted when req_vld & req_rdy
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  24  byte address; bits [1:0] ignored (forced 0)
- req_len  in  9  word count, 0..256
- req_done  out  1  one-cycle pulse when all chunks of the request have finished
- wdata_vld  in  1  write word valid
- wdata  in  32  write word, MSB sent first
- wdata_rdy  out  1  write word consumed this cycle
- rdata_vld  out  1  read word valid
- rdata  out  32  read word
- rdata_rdy  in  1  read sink ready
- start  out  1  to ctrl: one-cycle trigger
- cmd  out  8  to ctrl
- cmd_only  out  1  to ctrl
- cmd_width  out  2  to ctrl
- addr  out  24  to ctrl
- addr_width  out  2  to ctrl
- wait_cyc  out  4  to ctrl
- data_dir  out  1  to ctrl
- data_len  out  15  to ctrl
- data_width  out  2  to ctrl
- single_line_io_mode  out  1  to ctrl
- sck_div  out  4  to ctrl
- tx_vld  out  1  to ctrl
- tx_data  out  32  to ctrl
- tx_free  in  1  from ctrl
- rx_rdy  out  1  to ctrl
- rx_vld  in  1  from ctrl
- rx_data  in  32  from ctrl
- done  in  1  from ctrl

Behaviour:
- Reset values:
  - start=0, req_rdy=0, req_done=0, init_done=0.
  - cmd=0x00, cmd_only=0, all widths=00, addr=0, wait_cyc=0, data_dir=0, data_len=0, single_line_io_mode=0.
  - tx_vld=0, rx_rdy=0, wdata_rdy=0, rdata_vld=0.
  - State INIT_RSTEN.
  - Reset asserted mid-transfer aborts everything; init reruns after release.
- Width encoding: 00 single, 01 dual, 10 quad.
- Ctrl fields are registered and held stable from start until done. start is high for exactly one cycle per transaction.
- States and transitions:
  - INIT_RSTEN: cmd 0x66, cmd_only=1, single width. -> WAIT_DONE.
  - INIT_RST: cmd 0x99, cmd_only=1, single width. -> WAIT_DONE.
  - INIT_QE (only if QUAD_EN): cmd 0x35, cmd_only=1, single width. -> WAIT_DONE.
  - After the last init command completes: init_done <= 1, then IDLE.
  - IDLE: req_rdy=1. On handshake, latch cur_addr={req_addr[23:2],2'b00}, rem=req_len, dir=req_wr.
    - rem==0: req_done pulses the next cycle; back to IDLE with no ctrl traffic.
    - Otherwise -> ISSUE.
  - ISSUE: compute chunk=min(rem, (PAGE_BYTES-cur_addr mod PAGE_BYTES)/4, MAX_BURST_WORDS).
    - addr=cur_addr; data_len=chunk*4-1 (bytes minus 1); data_dir=dir.
    - QUAD_EN=1: write cmd 0x38, read cmd 0xEB with wait_cyc=RD_WAIT; all widths 10.
    - QUAD_EN=0: write 0x02, read 0x03; wait_cyc=0; widths 00.
    - Pulse start. -> WAIT_DONE.
  - WAIT_DONE: on done, cur_addr += chunk*4 (24-bit wrap), rem -= chunk.
    - rem==0: req_done pulse, -> IDLE.
    - Otherwise -> ISSUE.
  - Gap: minimum one idle cycle between done and the next start.
- Data path, active only in WAIT_DONE of a data transaction:
  - Write: tx_vld=wdata_vld; tx_data=wdata; wdata_rdy=tx_free.
  - Read: rx_rdy=rdata_rdy; rdata_vld=rx_vld; rdata=rx_data.
  - Outside these windows: tx_vld=0, rx_rdy=0, wdata_rdy=0, rdata_vld=0.
- Word-count check: words moved per chunk are counted. A mismatch with chunk at done sets a sticky internal flag for assertion checking only; it has no port.

Decomposition:
- Package psram_pkg holds:
  - width codes W_SINGLE / W_DUAL / W_QUAD;
  - command opcodes 0x66, 0x99, 0x35, 0x38, 0xEB, 0x02, 0x03;
  - state enumeration.
- One sub-module is natural: psram_chunk_calc, combinational min-of-three chunk sizing with data_len and next-address arithmetic.

Test Plan:
- Reset release, QUAD_EN=1 -> three transactions with cmd 0x66, 0x99, 0x35, each cmd_only=1 with single width; init_done=1 after the third done.
- Write at 0x000100, len 4 -> one start with cmd 0x38, addr 0x000100, data_len 15, widths 10; exactly 4 wdata_rdy pulses; one req_done.
- Read at 0x0003F8, len 4 -> two transactions:
  - first: cmd 0xEB, addr 0x0003F8, data_len 7, wait_cyc 6;
  - second: addr 0x000400, data_len 7;
  - 4 rdata words returned in order.
- Read at 0x000000, len 80, MAX_BURST_WORDS 32 -> chunks 32/32/16 at addresses 0x000, 0x080, 0x100; data_len 127/127/63.
- Request with len 0 -> no start; req_done exactly one cycle after acceptance.
- Read with rdata_rdy held low 20 cycles mid-burst -> rx_rdy low; no word lost or duplicated; reset asserted during the burst -> all outputs at reset values and init reruns.
